// File: rtl/test_pattern_source_if.sv
// Register-side bundle between the AXI4-Lite register wrapper and test_pattern_source.
//
// Signals:
//   control       RW control register: [0] enable, [2:1] mode, [3] clear, [7:4] chan_sel
//   seed          generator seed / constant value
//   data          head word of the selected channel FIFO (RO register)
//   data_rdStrobe one-cycle pulse when software reads the data register
//   status        RO status register
//
// Modports:
//   master  register wrapper side: drives control/seed/strobe, observes data/status
//   slave   pattern source side
interface test_pattern_source_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           control;
  logic [DATA_WIDTH-1:0] seed;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_rdStrobe;
  logic [31:0]           status;

  modport master (
    output control,
    output seed,
    output data_rdStrobe,
    input  data,
    input  status
  );

  modport slave (
    input  control,
    input  seed,
    input  data_rdStrobe,
    output data,
    output status
  );
endinterface

// File: rtl/test_pattern_source.sv
// Multi-channel, FIFO-buffered test pattern source.
//
// NUM_CHANNELS independent generators (counter, Galois LFSR, walking-one, constant) each fill
// their own FIFO at up to one word per cycle. Software selects one channel through
// control[7:4] and drains it through the data register; every read of data pulses
// data_rdStrobe, which pops the selected FIFO head.
//
// Ports:
//   axi_clk    sole clock
//   axi_reset  asynchronous, active-high reset
//   bus        test_pattern_source_if.slave register bundle
//                control [0] enable, [2:1] mode, [3] clear, [7:4] chan_sel
//                seed    generator seed / constant
//                data    head of selected FIFO, 0 when that FIFO is empty
//                status  [0] sel_empty, [1] sel_full, [2] underflow (sticky),
//                        [3] overflow_drop (always 0), [15:8] sel_level (saturating),
//                        [31:16] words_read
module test_pattern_source #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic                  axi_clk,
  input logic                  axi_reset,
  test_pattern_source_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {
    ModeCounter = 2'd0,
    ModeLfsr    = 2'd1,
    ModeWalk    = 2'd2,
    ModeConst   = 2'd3
  } mode_e;

  // Control decode
  logic          enable;
  logic          clear;
  mode_e         mode;
  logic [SW-1:0] sel_raw;
  logic [SW-1:0] sel;

  assign enable  = bus.control[0];
  assign mode    = mode_e'(bus.control[2:1]);
  assign clear   = bus.control[3];
  assign sel_raw = bus.control[4 +: SW];

  // Low select bits can exceed NUM_CHANNELS-1 when it is not a power of two; a single
  // subtraction completes the modulo because sel_raw < 2*NUM_CHANNELS.
  always_comb begin
    sel = sel_raw;
    if (32'(sel_raw) >= NUM_CHANNELS) begin
      sel = SW'(32'(sel_raw) - NUM_CHANNELS);
    end
  end

  logic unused_control;
  assign unused_control = ^bus.control;

  // Per-channel state
  logic [31:0]           gen_q   [NUM_CHANNELS];
  logic [AW-1:0]         wr_q    [NUM_CHANNELS];
  logic [AW-1:0]         rd_q    [NUM_CHANNELS];
  logic [CW-1:0]         count_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] mem_q   [NUM_CHANNELS][FIFO_DEPTH];

  logic                  underflow_q;
  logic [15:0]           words_read_q;

  logic [NUM_CHANNELS-1:0] empty;
  logic [NUM_CHANNELS-1:0] full;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;

  logic [31:0] seed_val [NUM_CHANNELS];
  logic [31:0] gen_next [NUM_CHANNELS];

  logic [31:0]           seed32;
  logic [31:0]           xor_seed;
  logic [DATA_WIDTH-1:0] walk_cur;

  // FIFO flags and push/pop qualification. clear suppresses both; a full FIFO may still
  // accept a push when the same cycle pops it.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      empty[c] = (count_q[c] == '0);
      full[c]  = (count_q[c] == CW'(FIFO_DEPTH));
      pop[c]   = bus.data_rdStrobe && !clear && !empty[c] && (sel == SW'(c));
      push[c]  = enable && !clear && (!full[c] || pop[c]);
    end
  end

  // Reseed values and next generator state for the currently selected mode.
  always_comb begin
    seed32   = 32'(bus.seed);
    xor_seed = '0;
    walk_cur = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      xor_seed = seed32 ^ 32'(c);
      walk_cur = gen_q[c][DATA_WIDTH-1:0];
      seed_val[c] = '0;
      gen_next[c] = gen_q[c];
      unique case (mode)
        ModeCounter: begin
          seed_val[c] = seed32 + 32'(c);
          gen_next[c] = gen_q[c] + 32'd1;
        end
        ModeLfsr: begin
          seed_val[c] = (xor_seed == '0) ? 32'd1 : xor_seed;
          // A zero state would lock the LFSR, so it is forced to 1 instead of advancing.
          if (gen_q[c] == '0) begin
            gen_next[c] = 32'd1;
          end else if (gen_q[c][0]) begin
            gen_next[c] = (gen_q[c] >> 1) ^ LfsrTaps;
          end else begin
            gen_next[c] = gen_q[c] >> 1;
          end
        end
        ModeWalk: begin
          seed_val[c] = 32'd1 << (c % DATA_WIDTH);
          gen_next[c] = 32'({walk_cur[DATA_WIDTH-2:0], walk_cur[DATA_WIDTH-1]});
        end
        ModeConst: begin
          seed_val[c] = xor_seed;
          gen_next[c] = gen_q[c];
        end
        default: begin
          seed_val[c] = '0;
          gen_next[c] = gen_q[c];
        end
      endcase
    end
  end

  // Generator, pointer, level and status state.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        gen_q[c]   <= '0;
        wr_q[c]    <= '0;
        rd_q[c]    <= '0;
        count_q[c] <= '0;
      end
      underflow_q  <= 1'b0;
      words_read_q <= '0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        gen_q[c]   <= seed_val[c];
        wr_q[c]    <= '0;
        rd_q[c]    <= '0;
        count_q[c] <= '0;
      end
      underflow_q  <= 1'b0;
      words_read_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (push[c]) begin
          gen_q[c] <= gen_next[c];
          wr_q[c]  <= wr_q[c] + AW'(1);
        end
        if (pop[c]) begin
          rd_q[c] <= rd_q[c] + AW'(1);
        end
        if (push[c] && !pop[c]) begin
          count_q[c] <= count_q[c] + CW'(1);
        end else if (pop[c] && !push[c]) begin
          count_q[c] <= count_q[c] - CW'(1);
        end
      end
      if (bus.data_rdStrobe) begin
        if (empty[sel]) begin
          underflow_q <= 1'b1;
        end else begin
          words_read_q <= words_read_q + 16'd1;
        end
      end
    end
  end

  // Storage needs no reset: reads are gated by the level counters.
  always_ff @(posedge axi_clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c]) begin
        mem_q[c][wr_q[c]] <= gen_q[c][DATA_WIDTH-1:0];
      end
    end
  end

  // Read side, combinational from the selected channel.
  logic [15:0] level_wide;
  logic [7:0]  sel_level;
  logic        sel_empty;
  logic        sel_full;

  always_comb begin
    level_wide = 16'(count_q[sel]);
    sel_level  = (level_wide > 16'd255) ? 8'hFF : level_wide[7:0];
    sel_empty  = empty[sel];
    sel_full   = full[sel];
  end

  assign bus.data   = sel_empty ? '0 : mem_q[sel][rd_q[sel]];
  assign bus.status = {words_read_q, sel_level, 4'b0000, 1'b0, underflow_q, sel_full, sel_empty};

endmodule

// File: tb/tb_test_pattern_source.sv
module tb_test_pattern_source;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  test_pattern_source_if #(.DATA_WIDTH(32)) bus ();
  test_pattern_source_if #(.DATA_WIDTH(8))  bus8 ();

  test_pattern_source #(
    .DATA_WIDTH  (32),
    .NUM_CHANNELS(4),
    .FIFO_DEPTH  (16)
  ) u_dut (
    .axi_clk  (clk),
    .axi_reset(rst),
    .bus      (bus)
  );

  test_pattern_source #(
    .DATA_WIDTH  (8),
    .NUM_CHANNELS(4),
    .FIFO_DEPTH  (16)
  ) u_dut8 (
    .axi_clk  (clk),
    .axi_reset(rst),
    .bus      (bus8)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];

  function automatic logic [31:0] ctrl(input logic en, input logic [1:0] mode, input logic clr,
                                       input logic [3:0] ch);
    return {24'h0, ch, clr, mode, en};
  endfunction

  function automatic logic [31:0] lfsr_model(input logic [31:0] s);
    if (s == 32'h0) return 32'h1;
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got 0x%0h, expected 0x0", bus.data);
    end
    checks++;
    if (bus.status !== 32'h1) begin
      errors++; $display("FAIL reset_status: got 0x%0h, expected 0x1", bus.status);
    end
    bus.data_rdStrobe = 1'b1;
    repeat (10) tick();
    bus.data_rdStrobe = 1'b0;
    checks++;
    if (bus.status[2] !== 1'b1) begin
      errors++; $display("FAIL underflow_sticky: got %0b, expected 1", bus.status[2]);
    end
    checks++;
    if (bus.status[31:16] !== 16'd0) begin
      errors++; $display("FAIL empty_reads_count: got %0d, expected 0", bus.status[31:16]);
    end
  endtask

  task automatic test_counter();
    logic [31:0] exp;
    bus.seed    = 32'h10;
    bus.control = ctrl(1'b0, 2'd0, 1'b1, 4'd2);
    tick();
    checks++;
    if (bus.status !== 32'h1) begin
      errors++; $display("FAIL clear_status: got 0x%0h, expected 0x1", bus.status);
    end
    bus.control = ctrl(1'b1, 2'd0, 1'b0, 4'd2);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h12 + 32'(i));
    repeat (20) tick();
    bus.control = ctrl(1'b0, 2'd0, 1'b0, 4'd2);
    checks++;
    if (bus.status[1] !== 1'b1) begin
      errors++; $display("FAIL counter_full: got %0b, expected 1", bus.status[1]);
    end
    checks++;
    if (bus.status[15:8] !== 8'd16) begin
      errors++; $display("FAIL counter_level: got %0d, expected 16", bus.status[15:8]);
    end
    bus.data_rdStrobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.data !== exp) begin
        errors++; $display("FAIL counter_word[%0d]: got 0x%0h, expected 0x%0h", i, bus.data, exp);
      end
      tick();
    end
    bus.data_rdStrobe = 1'b0;
    checks++;
    if (bus.status !== 32'h0010_0001) begin
      errors++; $display("FAIL counter_drained: got 0x%0h, expected 0x00100001", bus.status);
    end
    // chan_sel 4 wraps to channel 0, which filled from seed+0
    bus.control = ctrl(1'b0, 2'd0, 1'b0, 4'd4);
    #1;
    checks++;
    if (bus.data !== 32'h10) begin
      errors++; $display("FAIL chan_wrap_data: got 0x%0h, expected 0x10", bus.data);
    end
    checks++;
    if (bus.status !== 32'h0010_1002) begin
      errors++; $display("FAIL chan_wrap_status: got 0x%0h, expected 0x00101002", bus.status);
    end
    bus.control = ctrl(1'b0, 2'd0, 1'b0, 4'd13);
    #1;
    checks++;
    if (bus.data !== 32'h11) begin
      errors++; $display("FAIL chan_wrap13_data: got 0x%0h, expected 0x11", bus.data);
    end
    tick();
  endtask

  task automatic test_lfsr();
    logic [31:0] s;
    logic [31:0] exp;
    logic [31:0] first [2];
    bus.seed    = 32'h0;
    bus.control = ctrl(1'b0, 2'd1, 1'b1, 4'd0);
    tick();
    bus.control = ctrl(1'b1, 2'd1, 1'b0, 4'd0);
    s = 32'h1;
    for (int i = 0; i < 1000; i++) begin
      exp_q.push_back(s);
      s = lfsr_model(s);
    end
    tick();
    bus.data_rdStrobe = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      exp = exp_q.pop_front();
      if (i < 2) first[i] = bus.data;
      checks++;
      if (bus.data !== exp) begin
        errors++; $display("FAIL lfsr_word[%0d]: got 0x%0h, expected 0x%0h", i, bus.data, exp);
      end
      checks++;
      if (bus.data === 32'h0) begin
        errors++; $display("FAIL lfsr_nonzero[%0d]: got 0x0, expected nonzero", i);
      end
      tick();
    end
    bus.data_rdStrobe = 1'b0;
    bus.control       = 32'h0;
    checks++;
    if (first[0] !== 32'h1) begin
      errors++; $display("FAIL lfsr_first: got 0x%0h, expected 0x1", first[0]);
    end
    checks++;
    if (first[1] !== 32'h8020_0003) begin
      errors++; $display("FAIL lfsr_second: got 0x%0h, expected 0x80200003", first[1]);
    end
    checks++;
    if (bus.status[2] !== 1'b0) begin
      errors++; $display("FAIL lfsr_underflow: got %0b, expected 0", bus.status[2]);
    end
    tick();
  endtask

  task automatic test_walk();
    logic [7:0] w;
    logic [7:0] exp;
    bus8.seed    = 8'h0;
    bus8.control = ctrl(1'b0, 2'd2, 1'b1, 4'd1);
    tick();
    bus8.control = ctrl(1'b1, 2'd2, 1'b0, 4'd1);
    w = 8'h02;
    for (int i = 0; i < 10; i++) begin
      exp8_q.push_back(w);
      w = {w[6:0], w[7]};
    end
    tick();
    bus8.data_rdStrobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = exp8_q.pop_front();
      checks++;
      if (bus8.data !== exp) begin
        errors++; $display("FAIL walk_word[%0d]: got 0x%0h, expected 0x%0h", i, bus8.data, exp);
      end
      tick();
    end
    bus8.data_rdStrobe = 1'b0;
    bus8.control       = 32'h0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    bus.seed    = 32'h100;
    bus.control = ctrl(1'b0, 2'd0, 1'b1, 4'd3);
    tick();
    bus.control = ctrl(1'b1, 2'd0, 1'b0, 4'd3);
    for (int i = 0; i < 50; i++) exp_q.push_back(32'h103 + 32'(i));
    tick();
    bus.data_rdStrobe = 1'b1;
    for (int i = 0; i < 50; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.data !== exp) begin
        errors++; $display("FAIL b2b_word[%0d]: got 0x%0h, expected 0x%0h", i, bus.data, exp);
      end
      checks++;
      if (bus.status[15:8] !== 8'd1) begin
        errors++; $display("FAIL b2b_level[%0d]: got %0d, expected 1", i, bus.status[15:8]);
      end
      tick();
    end
    bus.data_rdStrobe = 1'b0;
    bus.control       = ctrl(1'b0, 2'd0, 1'b0, 4'd3);
    checks++;
    if (bus.status[2] !== 1'b0) begin
      errors++; $display("FAIL b2b_underflow: got %0b, expected 0", bus.status[2]);
    end
    checks++;
    if (bus.status[31:16] !== 16'd50) begin
      errors++; $display("FAIL b2b_words_read: got %0d, expected 50", bus.status[31:16]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    bus.seed    = 32'h50;
    bus.control = ctrl(1'b0, 2'd0, 1'b1, 4'd0);
    tick();
    bus.control = ctrl(1'b1, 2'd0, 1'b0, 4'd0);
    repeat (3) tick();
    checks++;
    if (bus.status[15:8] !== 8'd3) begin
      errors++; $display("FAIL mid_level: got %0d, expected 3", bus.status[15:8]);
    end
    bus.control = ctrl(1'b1, 2'd0, 1'b1, 4'd0);
    tick();
    checks++;
    if (bus.status !== 32'h1) begin
      errors++; $display("FAIL mid_clear: got 0x%0h, expected 0x1", bus.status);
    end
    bus.control = ctrl(1'b1, 2'd0, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus.data !== 32'h50) begin
      errors++; $display("FAIL mid_reseed: got 0x%0h, expected 0x50", bus.data);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.data !== 32'h0) begin
      errors++; $display("FAIL async_reset_data: got 0x%0h, expected 0x0", bus.data);
    end
    checks++;
    if (bus.status !== 32'h1) begin
      errors++; $display("FAIL async_reset_status: got 0x%0h, expected 0x1", bus.status);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    tick();
    bus.data_rdStrobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (bus.data !== exp) begin
        errors++; $display("FAIL restart_word[%0d]: got 0x%0h, expected 0x%0h", i, bus.data, exp);
      end
      tick();
    end
    bus.data_rdStrobe = 1'b0;
    bus.control       = 32'h0;
    tick();
  endtask

  initial begin
    rst                = 1'b1;
    bus.control        = 32'h0;
    bus.seed           = 32'h0;
    bus.data_rdStrobe  = 1'b0;
    bus8.control       = 32'h0;
    bus8.seed          = 8'h0;
    bus8.data_rdStrobe = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    test_reset();
    test_counter();
    test_lfsr();
    test_walk();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
